seg7_reader: RTL and testbench

SEG7_READER -- requirements
Module: seg7_reader

---
 rtl/seg7_pkg.sv | 43 ++++
 rtl/seg7_pat_dec.sv | 45 ++++
 rtl/seg7_reader.sv | 141 ++++++++++++++
 tb/tb_seg7_reader.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Purpose: shared constants and types for the seven-segment display reader.
// Latency: n/a (package only).
// Backpressure: n/a. Hex patterns are decoded only when SEG7_READER_HEX_EN is defined.
package seg7_pkg;

    localparam int CODE_W = 4;

    typedef logic [CODE_W-1:0] code_t;
    typedef logic [6:0]        pat_t;   // {g,f,e,d,c,b,a}, active-high

    localparam pat_t PAT_BLANK = 7'h00;
    localparam pat_t PAT_0     = 7'h3F;
    localparam pat_t PAT_1     = 7'h06;
    localparam pat_t PAT_2     = 7'h5B;
    localparam pat_t PAT_3     = 7'h4F;
    localparam pat_t PAT_4     = 7'h66;
    localparam pat_t PAT_5     = 7'h6D;
    localparam pat_t PAT_6     = 7'h7D;
    localparam pat_t PAT_7     = 7'h07;
    localparam pat_t PAT_8     = 7'h7F;
    localparam pat_t PAT_9     = 7'h6F;
    localparam pat_t PAT_A     = 7'h77;
    localparam pat_t PAT_B     = 7'h7C;
    localparam pat_t PAT_C     = 7'h39;
    localparam pat_t PAT_D     = 7'h5E;
    localparam pat_t PAT_E     = 7'h79;
    localparam pat_t PAT_F     = 7'h71;

    // Candidate symbol: blank flag plus code; a blank always carries code 0.
    typedef struct packed {
        logic  blank;
        code_t code;
    } sym_t;

    localparam sym_t SYM_BLANK = '{blank: 1'b1, code: '0};

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_TRACK,
        ST_LOCK
    } trk_state_t;

endpackage

// File: rtl/seg7_pat_dec.sv
// Purpose: map a sensed segment pattern to a code with digit/blank flags.
// Latency: purely combinational.
// Backpressure: none. A..F decode only when SEG7_READER_HEX_EN is defined.
module seg7_pat_dec
    import seg7_pkg::*;
(
    input  logic [6:0]        pat_i,
    output logic [CODE_W-1:0] code_o,
    output logic              valid_o,
    output logic              blank_o
);

    // Table lookup; anything not listed is undecodable (both flags low).
    always_comb begin
        code_o  = '0;
        valid_o = 1'b1;
        blank_o = 1'b0;
        case (pat_i)
            PAT_0: code_o = 4'h0;
            PAT_1: code_o = 4'h1;
            PAT_2: code_o = 4'h2;
            PAT_3: code_o = 4'h3;
            PAT_4: code_o = 4'h4;
            PAT_5: code_o = 4'h5;
            PAT_6: code_o = 4'h6;
            PAT_7: code_o = 4'h7;
            PAT_8: code_o = 4'h8;
            PAT_9: code_o = 4'h9;
`ifdef SEG7_READER_HEX_EN
            PAT_A: code_o = 4'hA;
            PAT_B: code_o = 4'hB;
            PAT_C: code_o = 4'hC;
            PAT_D: code_o = 4'hD;
            PAT_E: code_o = 4'hE;
            PAT_F: code_o = 4'hF;
`endif
            PAT_BLANK: begin
                valid_o = 1'b0;
                blank_o = 1'b1;
            end
            default: valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_reader.sv
// Purpose: debounce two multiplexed 7-seg digits into committed codes (SEG7_READER_HEX_EN adds A..F).
// Latency: 2-flop sync + STABLE_CNT samples; outputs visible after edge STABLE_CNT+1.
// Backpressure: none; samples with en low are dropped, chg/err are single-cycle pulses.
module seg7_reader
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CNT = 4
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        seg,
    input  logic              sel,
    input  logic              en,
    output logic [CODE_W-1:0] bcd1,
    output logic [CODE_W-1:0] bcd2,
    output logic              vld1,
    output logic              vld2,
    output logic              chg,
    output logic              err
);

    localparam logic [3:0] CNT_MAX = 4'(STABLE_CNT);

    logic [6:0] seg_s1_q, seg_s2_q;
    logic       sel_s1_q, sel_s2_q;
    logic       en_s1_q,  en_s2_q;

    logic [CODE_W-1:0] dec_code;
    logic              dec_valid, dec_blank;
    logic              smp_ok;
    sym_t              smp;

    trk_state_t        state_q [2], state_d [2];
    logic [3:0]        cnt_q   [2], cnt_d   [2];
    sym_t              cand_q  [2], cand_d  [2];
    logic [CODE_W-1:0] bcd_q   [2], bcd_d   [2];
    logic              vld_q   [2], vld_d   [2];
    logic              chg_q, chg_d, err_q, err_d;

    seg7_pat_dec u_dec (
        .pat_i   (seg_s2_q),
        .code_o  (dec_code),
        .valid_o (dec_valid),
        .blank_o (dec_blank)
    );

    assign smp_ok = dec_valid | dec_blank;
    assign smp    = '{blank: dec_blank, code: dec_code};

    // Per-digit tracker next state; only the digit addressed by the synced sel moves.
    always_comb begin
        logic commit;
        chg_d  = 1'b0;
        err_d  = 1'b0;
        commit = 1'b0;
        for (int d = 0; d < 2; d++) begin
            state_d[d] = state_q[d];
            cnt_d[d]   = cnt_q[d];
            cand_d[d]  = cand_q[d];
            bcd_d[d]   = bcd_q[d];
            vld_d[d]   = vld_q[d];
            commit     = 1'b0;
            if (en_s2_q && (sel_s2_q == 1'(d))) begin
                if (!smp_ok) begin
                    // Undecodable: restart counting on the held candidate.
                    err_d      = 1'b1;
                    cnt_d[d]   = '0;
                    state_d[d] = ST_TRACK;
                end else if (smp == cand_q[d]) begin
                    // Saturated count means already locked on this candidate.
                    if (cnt_q[d] < CNT_MAX) begin
                        cnt_d[d]   = cnt_q[d] + 4'd1;
                        state_d[d] = ST_TRACK;
                        commit     = (cnt_q[d] + 4'd1 == CNT_MAX);
                    end
                end else begin
                    cand_d[d]  = smp;
                    cnt_d[d]   = 4'd1;
                    state_d[d] = ST_TRACK;
                    commit     = (CNT_MAX == 4'd1);
                end
                if (commit) begin
                    state_d[d] = ST_LOCK;
                    if (cand_d[d].blank) begin
                        vld_d[d] = 1'b0;
                    end else begin
                        bcd_d[d] = cand_d[d].code;
                        vld_d[d] = 1'b1;
                    end
                    chg_d = (bcd_d[d] != bcd_q[d]) || (vld_d[d] != vld_q[d]);
                end
            end
        end
    end

    // Synchronizer, tracker state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1_q <= '0;
            seg_s2_q <= '0;
            sel_s1_q <= 1'b0;
            sel_s2_q <= 1'b0;
            en_s1_q  <= 1'b0;
            en_s2_q  <= 1'b0;
            chg_q    <= 1'b0;
            err_q    <= 1'b0;
            for (int d = 0; d < 2; d++) begin
                state_q[d] <= ST_EMPTY;
                cnt_q[d]   <= '0;
                cand_q[d]  <= SYM_BLANK;
                bcd_q[d]   <= '0;
                vld_q[d]   <= 1'b0;
            end
        end else begin
            seg_s1_q <= seg;
            seg_s2_q <= seg_s1_q;
            sel_s1_q <= sel;
            sel_s2_q <= sel_s1_q;
            en_s1_q  <= en;
            en_s2_q  <= en_s1_q;
            chg_q    <= chg_d;
            err_q    <= err_d;
            for (int d = 0; d < 2; d++) begin
                state_q[d] <= state_d[d];
                cnt_q[d]   <= cnt_d[d];
                cand_q[d]  <= cand_d[d];
                bcd_q[d]   <= bcd_d[d];
                vld_q[d]   <= vld_d[d];
            end
        end
    end

    assign bcd1 = bcd_q[0];
    assign bcd2 = bcd_q[1];
    assign vld1 = vld_q[0];
    assign vld2 = vld_q[1];
    assign chg  = chg_q;
    assign err  = err_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader: default instance (STABLE_CNT=4) plus a STABLE_CNT=1 instance.
// Expected values are hand-derived; hex expectations follow SEG7_READER_HEX_EN.
module tb_seg7_reader;

    logic       clk;
    logic       rst_n;
    logic [6:0] seg;
    logic       sel;
    logic       en;

    logic [3:0] bcd1, bcd2, u1_bcd1, u1_bcd2;
    logic       vld1, vld2, chg, err;
    logic       u1_vld1, u1_vld2, u1_chg, u1_err;

    int n_checks = 0;
    int n_err    = 0;
    int chg_cnt  = 0;
    int err_cnt  = 0;
    int u1_chg_cnt = 0;

`ifdef SEG7_READER_HEX_EN
    localparam logic [3:0] EXP_HEX_BCD = 4'hA;
    localparam int         EXP_HEX_ERR = 0;
    localparam int         EXP_HEX_CHG = 1;
`else
    localparam logic [3:0] EXP_HEX_BCD = 4'h1;
    localparam int         EXP_HEX_ERR = 4;
    localparam int         EXP_HEX_CHG = 0;
`endif

    seg7_reader dut (
        .clk(clk), .rst_n(rst_n), .seg(seg), .sel(sel), .en(en),
        .bcd1(bcd1), .bcd2(bcd2), .vld1(vld1), .vld2(vld2), .chg(chg), .err(err)
    );

    seg7_reader #(.STABLE_CNT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .seg(seg), .sel(sel), .en(en),
        .bcd1(u1_bcd1), .bcd2(u1_bcd2), .vld1(u1_vld1), .vld2(u1_vld2),
        .chg(u1_chg), .err(u1_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 ns after it and pulses are tallied.
    task automatic step();
        @(posedge clk);
        #1;
        if (chg)    chg_cnt++;
        if (err)    err_cnt++;
        if (u1_chg) u1_chg_cnt++;
    endtask

    task automatic clr_cnt();
        chg_cnt = 0;
        err_cnt = 0;
        u1_chg_cnt = 0;
    endtask

    task automatic flush();
        en = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        int first_a, first_b;

        // Reset state, with the first stimulus already applied.
        rst_n = 1'b1; seg = 7'h4F; sel = 1'b0; en = 1'b1;
        #1 rst_n = 1'b0;
        step(); step();
        check("rst_bcd1", bcd1, 0);
        check("rst_bcd2", bcd2, 0);
        check("rst_vld1", vld1, 0);
        check("rst_vld2", vld2, 0);
        check("rst_chg", chg, 0);
        check("rst_err", err, 0);
        #3 rst_n = 1'b1;
        clr_cnt();

        // seg=4F held: commit after edge 5 (edge 2 for STABLE_CNT=1).
        first_a = -1; first_b = -1;
        for (int i = 0; i <= 6; i++) begin
            step();
            if (vld1 && first_a < 0) first_a = i;
            if (u1_vld1 && first_b < 0) first_b = i;
            if (i == 5) check("lat_chg_pulse", chg, 1);
            if (i == 6) check("lat_chg_drop", chg, 0);
        end
        check("lat_commit_edge", first_a, 5);
        check("lat_bcd1", bcd1, 3);
        check("lat_chg_count", chg_cnt, 1);
        check("lat_bcd2", bcd2, 0);
        check("lat_vld2", vld2, 0);
        check("s1_commit_edge", first_b, 2);
        check("s1_bcd1", u1_bcd1, 3);

        // Alternating 4F/66: no commit on the filtered instance.
        clr_cnt();
        for (int i = 0; i < 12; i++) begin
            seg = (i % 2) ? 7'h66 : 7'h4F;
            step();
        end
        check("alt_chg_count", chg_cnt, 0);
        check("alt_err_count", err_cnt, 0);
        check("alt_bcd1", bcd1, 3);
        check("alt_vld1", vld1, 1);
        check("alt_s1_chg_count", u1_chg_cnt, 9);

        // Relock on 4F, one invalid sample, then four 66 samples needed.
        seg = 7'h4F;
        repeat (6) step();
        check("relock_bcd1", bcd1, 3);
        clr_cnt();
        seg = 7'h12;
        step();
        seg = 7'h66;
        first_a = -1; first_b = -1;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (err && first_a < 0) first_a = i;
            if (bcd1 == 4'd4 && first_b < 0) first_b = i;
        end
        check("inv_err_count", err_cnt, 1);
        check("inv_err_edge", first_a, 2);
        check("inv_commit_edge", first_b, 6);
        check("inv_chg_count", chg_cnt, 1);
        check("inv_vld1", vld1, 1);

        // Multiplexed digits with en=0 gaps carrying junk.
        clr_cnt();
        for (int r = 0; r < 4; r++) begin
            sel = 1'b0; en = 1'b1; seg = 7'h06; step();
            sel = 1'b1; seg = 7'h7F;            step();
            sel = 1'b0; en = 1'b0; seg = 7'h12; step();
            if (r == 2) begin
                flush();
                check("mux_pre_bcd1", bcd1, 4);
                check("mux_pre_vld2", vld2, 0);
            end
        end
        flush();
        check("mux_bcd1", bcd1, 1);
        check("mux_vld1", vld1, 1);
        check("mux_bcd2", bcd2, 8);
        check("mux_vld2", vld2, 1);
        check("mux_err_count", err_cnt, 0);
        check("mux_chg_count", chg_cnt, 2);

        // Hex pattern 77 on digit 1.
        clr_cnt();
        sel = 1'b0; en = 1'b1; seg = 7'h77;
        repeat (4) step();
        flush();
        check("hex_bcd1", bcd1, EXP_HEX_BCD);
        check("hex_vld1", vld1, 1);
        check("hex_err_count", err_cnt, EXP_HEX_ERR);
        check("hex_chg_count", chg_cnt, EXP_HEX_CHG);

        // Blank commit: vld drops, code holds.
        clr_cnt();
        en = 1'b1; seg = 7'h00;
        repeat (4) step();
        flush();
        check("blank_vld1", vld1, 0);
        check("blank_bcd1", bcd1, EXP_HEX_BCD);
        check("blank_chg_count", chg_cnt, 1);

        // Reset mid-count discards partial tracking.
        en = 1'b1; seg = 7'h4F;
        repeat (5) step();
        check("mid_vld1_precommit", vld1, 0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_bcd1", bcd1, 0);
        check("mid_rst_bcd2", bcd2, 0);
        check("mid_rst_vld2", vld2, 0);
        check("mid_rst_chg", chg, 0);
        check("mid_rst_err", err, 0);
        #1 rst_n = 1'b1;
        first_a = -1;
        for (int i = 0; i <= 7; i++) begin
            step();
            if (vld1 && first_a < 0) first_a = i;
        end
        check("mid_commit_edge", first_a, 5);
        check("mid_bcd1", bcd1, 3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
